// File: rtl/stream_mux_arb.sv
// stream_mux_arb
//   N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes and
//   a single registered output stage. The granted channel is chosen either
//   by an external select (fixed mode) or by a round-robin search that
//   starts at the channel after the last one served.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_mode       0 = fixed select via i_sel, 1 = round-robin
//   i_sel        channel select for fixed mode (out-of-range stalls all)
//   i_in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//   i_in_valid   per-channel valid
//   o_in_ready   per-channel ready (combinational)
//   o_out_data   registered output data
//   o_out_ch     registered id of the channel that supplied o_out_data
//   o_out_valid  registered output valid
//   i_out_ready  consumer ready
//
// Output stage states
//   state    | meaning
//   ST_EMPTY | no beat held, o_out_valid = 0
//   ST_FULL  | beat held,    o_out_valid = 1

module stream_mux_arb #(
    parameter  int WIDTH = 4,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_mode,
    input  logic [SELW-1:0]      i_sel,
    input  logic [NCH*WIDTH-1:0] i_in_data,
    input  logic [NCH-1:0]       i_in_valid,
    output logic [NCH-1:0]       o_in_ready,
    output logic [WIDTH-1:0]     o_out_data,
    output logic [SELW-1:0]      o_out_ch,
    output logic                 o_out_valid,
    input  logic                 i_out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SELW-1:0]   r_rr_ptr;
    logic [WIDTH-1:0]  r_out_data;
    logic [SELW-1:0]   r_out_ch;

    logic [NCH-1:0]    w_grant;
    logic [SELW-1:0]   w_gnt_id;
    logic              w_found;
    logic [SELW:0]     w_sum;
    logic [WIDTH-1:0]  w_gnt_data;
    logic              w_can_load;
    logic              w_xfer;

    // Grant selection. In round-robin mode the candidate index is
    // rr_ptr + k folded back into 0..NCH-1; one extra bit on the sum keeps
    // the wrap correct when NCH is not a power of two.
    always_comb begin
        w_grant  = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        if (!i_mode) begin
            if ({1'b0, i_sel} < NCH_W) begin
                w_grant[i_sel] = 1'b1;
                w_gnt_id       = i_sel;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                w_sum = {1'b0, r_rr_ptr} + (SELW+1)'(k);
                if (w_sum >= NCH_W) begin
                    w_sum = w_sum - NCH_W;
                end
                if (!w_found && i_in_valid[w_sum[SELW-1:0]]) begin
                    w_found                  = 1'b1;
                    w_grant[w_sum[SELW-1:0]] = 1'b1;
                    w_gnt_id                 = w_sum[SELW-1:0];
                end
            end
        end
    end

    // One-hot AND-OR data mux; avoids a variable part-select that could
    // run past the bus for an out-of-range select.
    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant[i]) begin
                w_gnt_data = i_in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign o_out_valid = (r_state == ST_FULL);
    assign w_can_load  = ~o_out_valid | i_out_ready;
    assign o_in_ready  = w_grant & {NCH{w_can_load}};
    assign w_xfer      = |(o_in_ready & i_in_valid);
    assign o_out_data  = r_out_data;
    assign o_out_ch    = r_out_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
            ST_FULL:  if (!w_xfer && i_out_ready) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Data and channel id only move on a transfer; a plain drain leaves
    // them as they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_rr_ptr   <= '0;
        end else if (w_xfer) begin
            r_out_data <= w_gnt_data;
            r_out_ch   <= w_gnt_id;
            r_rr_ptr   <= (w_gnt_id == SELW'(NCH-1)) ? '0 : w_gnt_id + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
module tb_stream_mux_arb;

    logic        clk;
    logic        rst_n;

    logic        a_mode;
    logic [1:0]  a_sel;
    logic [15:0] a_din;
    logic [3:0]  a_vld;
    logic [3:0]  a_rdy;
    logic [3:0]  a_od;
    logic [1:0]  a_oc;
    logic        a_ov;
    logic        a_ordy;

    logic        b_mode;
    logic [1:0]  b_sel;
    logic [11:0] b_din;
    logic [2:0]  b_vld;
    logic [2:0]  b_rdy;
    logic [3:0]  b_od;
    logic [1:0]  b_oc;
    logic        b_ov;
    logic        b_ordy;

    int n_tests;
    int n_fail;

    stream_mux_arb #(.WIDTH(4), .NCH(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mode      (a_mode),
        .i_sel       (a_sel),
        .i_in_data   (a_din),
        .i_in_valid  (a_vld),
        .o_in_ready  (a_rdy),
        .o_out_data  (a_od),
        .o_out_ch    (a_oc),
        .o_out_valid (a_ov),
        .i_out_ready (a_ordy)
    );

    stream_mux_arb #(.WIDTH(4), .NCH(3)) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mode      (b_mode),
        .i_sel       (b_sel),
        .i_in_data   (b_din),
        .i_in_valid  (b_vld),
        .o_in_ready  (b_rdy),
        .o_out_data  (b_od),
        .o_out_ch    (b_oc),
        .o_out_valid (b_ov),
        .i_out_ready (b_ordy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [15:0] din;
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  erdy;
        logic        eov;
        logic [3:0]  eod;
        logic [1:0]  eoc;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference arbitration: -1 means no channel granted.
    function automatic int model_grant(input logic m, input int s, input logic [3:0] v, input int ptr);
        if (!m) return (s < 4) ? s : -1;
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    logic       m_valid;
    logic [3:0] m_data;
    int         m_ch;
    int         m_ptr;
    int         g;
    logic       can;
    logic [3:0] exp_rdy;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        a_mode = 1'b0; a_sel = 2'd0; a_din = 16'h0; a_vld = 4'h0; a_ordy = 1'b1;
        b_mode = 1'b0; b_sel = 2'd0; b_din = 12'h0; b_vld = 3'h0; b_ordy = 1'b1;

        tbl[0]  = '{1'b1, 2'd0, 16'h4321, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        tbl[1]  = '{1'b1, 2'd0, 16'h4321, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
        tbl[2]  = '{1'b1, 2'd0, 16'h4321, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2};
        tbl[3]  = '{1'b1, 2'd0, 16'h4321, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3};
        tbl[4]  = '{1'b1, 2'd0, 16'h4321, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        tbl[5]  = '{1'b0, 2'd2, 16'h0A00, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2};
        tbl[6]  = '{1'b0, 2'd1, 16'h0050, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1};
        tbl[7]  = '{1'b0, 2'd2, 16'h0700, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'h7, 2'd2};
        tbl[8]  = '{1'b1, 2'd0, 16'h0090, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'h9, 2'd1};
        tbl[9]  = '{1'b1, 2'd0, 16'hE00D, 4'b1001, 1'b1, 4'b1000, 1'b1, 4'hE, 2'd3};
        tbl[10] = '{1'b1, 2'd0, 16'hE00D, 4'b1001, 1'b1, 4'b0001, 1'b1, 4'hD, 2'd0};
        tbl[11] = '{1'b1, 2'd0, 16'h0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'hD, 2'd0};
        tbl[12] = '{1'b1, 2'd0, 16'hFFFF, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'hD, 2'd0};
        tbl[13] = '{1'b0, 2'd3, 16'h8888, 4'b1000, 1'b0, 4'b0000, 1'b1, 4'hD, 2'd0};
        tbl[14] = '{1'b1, 2'd0, 16'h1234, 4'b0110, 1'b1, 4'b0010, 1'b1, 4'h3, 2'd1};
        tbl[15] = '{1'b1, 2'd0, 16'h1234, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'h3, 2'd1};
        tbl[16] = '{1'b1, 2'd0, 16'h0B00, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'hB, 2'd2};
        tbl[17] = '{1'b0, 2'd0, 16'h0001, 4'b0001, 1'b0, 4'b0000, 1'b1, 4'hB, 2'd2};

        // Reset values
        #1;
        check("reset ov", 32'(a_ov), 32'd0);
        check("reset od", 32'(a_od), 32'd0);
        check("reset oc", 32'(a_oc), 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: fairness, fixed select, skip/wrap, backpressure
        for (int i = 0; i < 18; i++) begin
            a_mode = tbl[i].mode; a_sel = tbl[i].sel; a_din = tbl[i].din;
            a_vld  = tbl[i].vld;  a_ordy = tbl[i].ordy;
            #2;
            check($sformatf("tbl%0d rdy", i), 32'(a_rdy), 32'(tbl[i].erdy));
            @(posedge clk); #1;
            check($sformatf("tbl%0d ov", i), 32'(a_ov), 32'(tbl[i].eov));
            check($sformatf("tbl%0d od", i), 32'(a_od), 32'(tbl[i].eod));
            check($sformatf("tbl%0d oc", i), 32'(a_oc), 32'(tbl[i].eoc));
        end

        // Asynchronous reset mid-cycle with a beat held
        a_mode = 1'b0; a_sel = 2'd0; a_vld = 4'h0; a_ordy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async rst ov", 32'(a_ov), 32'd0);
        check("async rst od", 32'(a_od), 32'd0);
        check("async rst oc", 32'(a_oc), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post rst ov", 32'(a_ov), 32'd0);

        // Round-robin pointer restarts at channel 0 after reset
        a_mode = 1'b1; a_din = 16'h4321; a_vld = 4'b1111; a_ordy = 1'b1;
        #2;
        check("rr restart rdy", 32'(a_rdy), 32'b0001);
        @(posedge clk); #1;
        check("rr restart oc", 32'(a_oc), 32'd0);
        check("rr restart od", 32'(a_od), 32'd1);

        // Randomised run against the reference model
        m_valid = 1'b1; m_data = 4'h1; m_ch = 0; m_ptr = 1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) a_mode = ~a_mode;
            a_sel  = 2'($urandom_range(0, 3));
            a_din  = 16'($urandom);
            a_vld  = 4'($urandom);
            a_ordy = ($urandom_range(0, 3) != 0);
            g       = model_grant(a_mode, int'(a_sel), a_vld, m_ptr);
            can     = !m_valid || a_ordy;
            exp_rdy = (g >= 0 && can) ? 4'(1 << g) : 4'b0000;
            #2;
            check($sformatf("rnd%0d rdy", n), 32'(a_rdy), 32'(exp_rdy));
            if (g >= 0 && a_vld[g] && can) begin
                m_valid = 1'b1;
                m_data  = a_din[g*4 +: 4];
                m_ch    = g;
                m_ptr   = (g + 1) % 4;
            end else if (m_valid && a_ordy) begin
                m_valid = 1'b0;
            end
            @(posedge clk); #1;
            check($sformatf("rnd%0d ov", n), 32'(a_ov), 32'(m_valid));
            check($sformatf("rnd%0d od", n), 32'(a_od), 32'(m_data));
            check($sformatf("rnd%0d oc", n), 32'(a_oc), 32'(m_ch));
        end

        // Out-of-range select on a three-channel instance
        b_mode = 1'b0; b_sel = 2'd0; b_din = 12'h00C; b_vld = 3'b001; b_ordy = 1'b0;
        @(posedge clk); #1;
        check("nch3 load ov", 32'(b_ov), 32'd1);
        check("nch3 load od", 32'(b_od), 32'hC);
        b_sel = 2'd3; b_vld = 3'b111; b_din = 12'h777; b_ordy = 1'b1;
        #2;
        check("nch3 oor rdy", 32'(b_rdy), 32'd0);
        @(posedge clk); #1;
        check("nch3 drain ov", 32'(b_ov), 32'd0);
        check("nch3 drain od", 32'(b_od), 32'hC);
        #2;
        check("nch3 oor rdy2", 32'(b_rdy), 32'd0);
        @(posedge clk); #1;
        check("nch3 idle ov", 32'(b_ov), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
